pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Drives the enable and bubble inputs of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Resolves the following into per-stage enables and NOP/bubble injects: load-use hazards, taken branches/jumps resolved in EX, multicycle instruction-memory and data-memory stalls, and halt.

Parameters:
REG_AW, 3, register-specifier width
PERF_W, 16, stall-counter width (optional feature only)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
id_rs  in  REG_AW  ID-stage source A specifier
id_rt  in  REG_AW  ID-stage source B specifier
id_rs_used  in  1  source A read by ID instruction
id_rt_used  in  1  source B read by ID instruction
ex_rd  in  REG_AW  EX-stage destination
ex_regwrite  in  1  EX instruction writes register file
ex_memread  in  1  EX instruction is a load
mem_rd, wb_rd  in  REG_AW  MEM/WB destinations (used when forwarding compiled out)
mem_regwrite, wb_regwrite  in  1  MEM/WB write enables
ex_br_taken  in  1  branch/jump taken, resolved in EX
imem_stall  in  1  instruction memory busy
imem_done  in  1  instruction memory data valid this cycle
dmem_stall  in  1  data memory busy
dmem_done  in  1  data memory access complete this cycle
wb_halt  in  1  HALT reached WB
pc_en  out  1  PC register load enable
ifid_en  out  1  IF/ID enable
ifid_nop  out  1  IF/ID loads NOP (0x0800) instead of fetched word
idex_en  out  1  ID/EX enable
idex_bubble  out  1  drives ID/EX En low (kills RegWrite/DMemWrite/DMemEn)
exmem_en  out  1  EX/MEM enable
memwb_en  out  1  MEM/WB enable
halted  out  1  processor halted

Behaviour:
- FSM states: RUN, IWAIT, DWAIT, HALT. Registered state plus one registered flag flush_pend.
- Reset (rst low, asynchronous):
  - state = RUN, flush_pend = 0.
  - While rst is low: all *_en = 0, ifid_nop = 1, idex_bubble = 1, halted = 0.
- Outputs are combinational from state and inputs. Evaluation priority: wb_halt > dmem > taken branch > load-use > imem.
- HALT:
  - Entered on the cycle after wb_halt = 1 in any state.
  - All enables 0, halted = 1. Exit only via reset.
- DWAIT:
  - Entered when dmem_stall = 1 in RUN or IWAIT.
  - Entry cycle and all DWAIT cycles: every *_en = 0 (whole pipe frozen). ex_br_taken and the load-use check are ignored.
  - Cycle with dmem_done = 1: all enables 1; next state RUN, or IWAIT if imem_stall = 1.
- Taken branch (RUN, no dmem):
  - pc_en = 1, ifid_en = 1 with ifid_nop = 1, idex_en = 1 with idex_bubble = 1. Two wrong-path slots squashed.
- Taken branch in IWAIT:
  - Apply the same squash and set flush_pend = 1.
  - When imem_done arrives, the returned word is discarded (ifid_nop = 1) and flush_pend clears.
- Load-use:
  - Condition: ex_memread & ex_regwrite & ((id_rs_used & id_rs == ex_rd) | (id_rt_used & id_rt == ex_rd)).
  - Response: pc_en = 0, ifid_en = 0, idex_en = 1 with idex_bubble = 1. Exactly one bubble per load.
  - ex_regwrite = 0 never matches.
- IWAIT:
  - Entered when imem_stall = 1.
  - pc_en = 0; IF/ID loads NOP; downstream stages enabled.
  - Exit to RUN on imem_done = 1: pc_en = 1, ifid_nop = flush_pend.
- imem_done and imem_stall asserted together: treat as done.
- Reset mid-IWAIT/DWAIT: state aborts to RUN; the memories are reset by the same rst.

Optional Feature:
Macro PIPE_CTRL_FORWARD_EN.
- Defined: forwarding exists; only the load-use case stalls.
- Undefined: any ID source matching EX/MEM/WB destination with its regwrite set stalls.
  - Stall response: pc_en = 0, ifid_en = 0, idex_bubble = 1.
  - Repeats until the producer has left WB; up to 3 bubbles.
  - WB match counts (no write-before-read register file assumed).

Decomposition:
- Shared package pipe_pkg:
  - FSM state encoding (2-bit).
  - NOP_INSTR = 16'h0800.
  - REG_AW.
- One sub-module hazard_cmp: combinational source/destination comparator.
  - Instantiated once per checked producer stage.
  - Returns a match flag; keeps the ifdef local to pipe_ctrl.

Test Plan:
- Load-use: EX ld r2 (ex_memread = 1, ex_rd = 2), ID add reads r2 -> one cycle of pc_en = 0, ifid_en = 0, idex_bubble = 1; next cycle all enables 1.
- Taken branch: ex_br_taken = 1 in RUN -> same cycle ifid_nop = 1, idex_bubble = 1, pc_en = 1; no stall cycles.
- DMEM stall: dmem_stall for 4 cycles, then dmem_done; ex_br_taken = 1 held throughout -> all enables 0 for 4 cycles; squash applied only on the release cycle.
- IMEM miss with branch: imem_stall 3 cycles, ex_br_taken during cycle 2 -> on imem_done, ifid_nop = 1 (flush_pend honoured), state RUN.
- Halt: wb_halt = 1 -> next cycle halted = 1, all enables 0, held 10 cycles. rst low asynchronously mid-cycle -> immediate outputs per reset, halted = 0; RUN after release.
- Without PIPE_CTRL_FORWARD_EN: add r3 in EX, ID reads r3 -> 3 consecutive bubbles. With the macro defined -> 0 bubbles.

Source files
------------

// File: rtl/pipe_pkg.sv
// Purpose : shared types and constants for the pipeline stall/flush sequencer.
// Latency : n/a (declarations only).
// Backpressure: n/a.
// Contents: sequencer state encoding, register-specifier width, NOP word,
//           stall-counter width.
package pipe_pkg;

  localparam int REG_AW = 3;
  localparam int PERF_W = 16;

  // Word loaded into IF/ID whenever a fetch slot is squashed or empty.
  localparam logic [15:0] NOP_INSTR = 16'h0800;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    IWAIT = 2'd1,
    DWAIT = 2'd2,
    HALT  = 2'd3
  } pipeState_t;

endpackage

// File: rtl/hazard_cmp.sv
// Purpose : flags a RAW dependency between the ID instruction's sources and
//           one producer stage's destination.
// Latency : combinational.
// Backpressure: none; pure comparator.
// Ports   : srcA/srcB + used flags (ID sources), dst + dstWrite (producer),
//           match (dependency present).
module hazard_cmp
  import pipe_pkg::*;
#(
  parameter int AW = REG_AW
) (
  input  logic [AW-1:0] srcA,
  input  logic          srcAUsed,
  input  logic [AW-1:0] srcB,
  input  logic          srcBUsed,
  input  logic [AW-1:0] dst,
  input  logic          dstWrite,
  output logic          match
);

  // A producer that does not write the register file can never conflict.
  assign match = dstWrite & ((srcAUsed & (srcA == dst)) | (srcBUsed & (srcB == dst)));

endmodule

// File: rtl/pipe_ctrl.sv
// Purpose : central stall/flush sequencer for the 5-stage pipeline; drives the
//           PC, IF/ID, ID/EX, EX/MEM and MEM/WB enables and NOP/bubble injects.
// Latency : outputs are combinational from state and inputs; state updates on clk.
// Backpressure: dmem busy freezes the whole pipe, imem busy holds the PC and
//           feeds NOPs into IF/ID, data hazards hold PC and IF/ID for a bubble.
// Ports   : clk, rst (async, active-low); ID sources, EX/MEM/WB destinations,
//           branch and memory handshakes, wb_halt in; stage enables, ifid_nop,
//           idex_bubble, halted out.
// Build option: define PIPE_CTRL_FORWARD_EN when the datapath forwards, so
//           only load-use stalls; otherwise any EX/MEM/WB producer match stalls.
module pipe_ctrl #(
  parameter int REG_AW = pipe_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_regwrite,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              mem_regwrite,
  input  logic              wb_regwrite,
  input  logic              ex_br_taken,
  input  logic              imem_stall,
  input  logic              imem_done,
  input  logic              dmem_stall,
  input  logic              dmem_done,
  input  logic              wb_halt,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              ifid_nop,
  output logic              idex_en,
  output logic              idex_bubble,
  output logic              exmem_en,
  output logic              memwb_en,
  output logic              halted
);

  import pipe_pkg::*;

  pipeState_t state, nextState;
  logic       flushPend, nextFlushPend;
  logic       exMatch;
  logic       stallHazard;
  logic       imemBusy;
  logic       dmemHold;

  hazard_cmp #(.AW(REG_AW)) exCmp (
    .srcA     (id_rs),
    .srcAUsed (id_rs_used),
    .srcB     (id_rt),
    .srcBUsed (id_rt_used),
    .dst      (ex_rd),
    .dstWrite (ex_regwrite),
    .match    (exMatch)
  );

`ifdef PIPE_CTRL_FORWARD_EN
  // Forwarding covers every ALU result; only a load in EX is too late.
  assign stallHazard = exMatch & ex_memread;

  logic unusedLateProducers;
  assign unusedLateProducers = ^{mem_rd, wb_rd, mem_regwrite, wb_regwrite};
`else
  logic memMatch, wbMatch;

  hazard_cmp #(.AW(REG_AW)) memCmp (
    .srcA     (id_rs),
    .srcAUsed (id_rs_used),
    .srcB     (id_rt),
    .srcBUsed (id_rt_used),
    .dst      (mem_rd),
    .dstWrite (mem_regwrite),
    .match    (memMatch)
  );

  // The register file does not write-before-read, so a WB producer still stalls.
  hazard_cmp #(.AW(REG_AW)) wbCmp (
    .srcA     (id_rs),
    .srcAUsed (id_rs_used),
    .srcB     (id_rt),
    .srcBUsed (id_rt_used),
    .dst      (wb_rd),
    .dstWrite (wb_regwrite),
    .match    (wbMatch)
  );

  assign stallHazard = exMatch | memMatch | wbMatch;

  logic unusedMemread;
  assign unusedMemread = ex_memread;
`endif

  // In IWAIT the fetch stays outstanding until imem_done, regardless of
  // imem_stall; elsewhere a new miss starts with imem_stall. Done wins a tie.
  assign imemBusy = (state == IWAIT) ? ~imem_done : (imem_stall & ~imem_done);
  assign dmemHold = (state == DWAIT) ? ~dmem_done : dmem_stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      flushPend <= 1'b0;
    end else begin
      state     <= nextState;
      flushPend <= nextFlushPend;
    end
  end

  always_comb begin
    nextState     = state;
    nextFlushPend = flushPend;
    if (state != HALT) begin
      if (wb_halt) begin
        nextState = HALT;
      end else if (dmemHold) begin
        // flushPend rides through the data wait untouched.
        nextState = DWAIT;
      end else begin
        nextState = imemBusy ? IWAIT : RUN;
        // A branch taken while a fetch is outstanding makes that fetch
        // wrong-path; remember to drop it when it finally returns.
        nextFlushPend = imemBusy & (ex_br_taken | flushPend);
      end
    end
  end

  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    ifid_nop    = 1'b0;
    idex_en     = 1'b0;
    idex_bubble = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    halted      = 1'b0;
    if (!rst) begin
      ifid_nop    = 1'b1;
      idex_bubble = 1'b1;
    end else if (state == HALT) begin
      halted = 1'b1;
    end else if (wb_halt || dmemHold) begin
      // Whole pipe frozen: every enable stays low.
    end else if (ex_br_taken) begin
      // Squash the two wrong-path slots while loading the target PC.
      pc_en       = 1'b1;
      ifid_en     = 1'b1;
      ifid_nop    = 1'b1;
      idex_en     = 1'b1;
      idex_bubble = 1'b1;
      exmem_en    = 1'b1;
      memwb_en    = 1'b1;
    end else if (stallHazard) begin
      idex_en     = 1'b1;
      idex_bubble = 1'b1;
      exmem_en    = 1'b1;
      memwb_en    = 1'b1;
    end else if (imemBusy) begin
      ifid_en  = 1'b1;
      ifid_nop = 1'b1;
      idex_en  = 1'b1;
      exmem_en = 1'b1;
      memwb_en = 1'b1;
    end else begin
      pc_en    = 1'b1;
      ifid_en  = 1'b1;
      ifid_nop = flushPend;
      idex_en  = 1'b1;
      exmem_en = 1'b1;
      memwb_en = 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Purpose : self-checking bench for pipe_ctrl: directed literal patterns plus
//           randomized traffic against a behavioural model of the stall rules.
// Latency : outputs checked each negedge (combinational from state + inputs).
// Backpressure: n/a.
module tb_pipe_ctrl;

  localparam int AW = pipe_pkg::REG_AW;

  // Output vector order: {pc_en, ifid_en, ifid_nop, idex_en, idex_bubble,
  //                       exmem_en, memwb_en, halted}
  localparam logic [7:0] V_RESET  = 8'b00101000;
  localparam logic [7:0] V_GO     = 8'b11010110;
  localparam logic [7:0] V_GO_NOP = 8'b11110110;
  localparam logic [7:0] V_FREEZE = 8'b00000000;
  localparam logic [7:0] V_HALTED = 8'b00000001;
  localparam logic [7:0] V_BRANCH = 8'b11111110;
  localparam logic [7:0] V_HAZ    = 8'b00011110;
  localparam logic [7:0] V_IFWAIT = 8'b01110110;
`ifdef PIPE_CTRL_FORWARD_EN
  localparam logic [7:0] V_ALU_DEP = V_GO;
  localparam int         ALU_BUBBLES = 0;
`else
  localparam logic [7:0] V_ALU_DEP = V_HAZ;
  localparam int         ALU_BUBBLES = 3;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] id_rs, id_rt, ex_rd, mem_rd, wb_rd;
  logic          id_rs_used, id_rt_used, ex_regwrite, ex_memread;
  logic          mem_regwrite, wb_regwrite, ex_br_taken;
  logic          imem_stall, imem_done, dmem_stall, dmem_done, wb_halt;
  logic          pc_en, ifid_en, ifid_nop, idex_en, idex_bubble;
  logic          exmem_en, memwb_en, halted;

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_regwrite(mem_regwrite), .wb_regwrite(wb_regwrite),
    .ex_br_taken(ex_br_taken), .imem_stall(imem_stall), .imem_done(imem_done),
    .dmem_stall(dmem_stall), .dmem_done(dmem_done), .wb_halt(wb_halt),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_nop(ifid_nop), .idex_en(idex_en),
    .idex_bubble(idex_bubble), .exmem_en(exmem_en), .memwb_en(memwb_en), .halted(halted)
  );

  wire [7:0] dutVec = {pc_en, ifid_en, ifid_nop, idex_en, idex_bubble, exmem_en, memwb_en, halted};

  int compared = 0;
  int mismatched = 0;
  bit cmpEn = 1'b0;

  // ---------------- behavioural model ----------------
  // The processor is described by what it is waiting for, not by a state code.
  bit mHalted = 1'b0;  // HALT retired, frozen until reset
  bit mData   = 1'b0;  // a data-memory access is outstanding
  bit mFetch  = 1'b0;  // an instruction fetch is outstanding
  bit mDiscard = 1'b0; // the outstanding (or next returned) fetch is wrong-path

  function automatic bit readsReg(input logic [AW-1:0] r);
    return (id_rs_used && id_rs == r) || (id_rt_used && id_rt == r);
  endfunction

  function automatic bit mustStall();
`ifdef PIPE_CTRL_FORWARD_EN
    return ex_memread && ex_regwrite && readsReg(ex_rd);
`else
    logic [AW-1:0] dst[3];
    bit            wr[3];
    bit            hit;
    dst = '{ex_rd, mem_rd, wb_rd};
    wr  = '{ex_regwrite, mem_regwrite, wb_regwrite};
    hit = 1'b0;
    for (int p = 0; p < 3; p++) if (wr[p] && readsReg(dst[p])) hit = 1'b1;
    return hit;
`endif
  endfunction

  function automatic bit fetchBusy();
    return mFetch ? !imem_done : (imem_stall && !imem_done);
  endfunction

  function automatic bit dataBusy();
    return mData ? !dmem_done : dmem_stall;
  endfunction

  function automatic logic [7:0] expected();
    if (!rst)                     return V_RESET;
    if (mHalted)                  return V_HALTED;
    if (wb_halt || dataBusy())    return V_FREEZE;
    if (ex_br_taken)              return V_BRANCH;
    if (mustStall())              return V_HAZ;
    if (fetchBusy())              return V_IFWAIT;
    return mDiscard ? V_GO_NOP : V_GO;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mHalted  <= 1'b0;
      mData    <= 1'b0;
      mFetch   <= 1'b0;
      mDiscard <= 1'b0;
    end else if (!mHalted) begin
      if (wb_halt) begin
        mHalted <= 1'b1;
      end else if (dataBusy()) begin
        mData  <= 1'b1;
        mFetch <= 1'b0;
      end else begin : advance
        bit fb;
        fb = fetchBusy();
        mData    <= 1'b0;
        mFetch   <= fb;
        mDiscard <= fb && (ex_br_taken || mDiscard);
      end
    end
  end

  // Model comparison on every falling edge.
  always @(negedge clk) begin
    if (cmpEn) begin : cmp
      logic [7:0] e;
      e = expected();
      compared++;
      if (dutVec !== e) begin
        mismatched++;
        $display("FAIL model t=%0t: got %b want %b", $time, dutVec, e);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    id_rs = '0; id_rt = '0; id_rs_used = 1'b0; id_rt_used = 1'b0;
    ex_rd = '0; ex_regwrite = 1'b0; ex_memread = 1'b0;
    mem_rd = '0; wb_rd = '0; mem_regwrite = 1'b0; wb_regwrite = 1'b0;
    ex_br_taken = 1'b0; imem_stall = 1'b0; imem_done = 1'b0;
    dmem_stall = 1'b0; dmem_done = 1'b0; wb_halt = 1'b0;
  endtask

  task automatic nextCyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] want);
    compared++;
    if (dutVec !== want) begin
      mismatched++;
      $display("FAIL %s: got %b want %b", name, dutVec, want);
    end
  endtask

  task automatic pin(input string name, input logic [7:0] want);
    @(negedge clk);
    #1;
    chk(name, want);
  endtask

  task automatic randomize_inputs();
    id_rs        = AW'($urandom_range(0, 3));
    id_rt        = AW'($urandom_range(0, 3));
    ex_rd        = AW'($urandom_range(0, 3));
    mem_rd       = AW'($urandom_range(0, 3));
    wb_rd        = AW'($urandom_range(0, 3));
    id_rs_used   = $urandom_range(0, 1) == 0;
    id_rt_used   = $urandom_range(0, 1) == 0;
    ex_regwrite  = $urandom_range(0, 1) == 0;
    ex_memread   = $urandom_range(0, 2) == 0;
    mem_regwrite = $urandom_range(0, 2) == 0;
    wb_regwrite  = $urandom_range(0, 2) == 0;
    ex_br_taken  = $urandom_range(0, 5) == 0;
    imem_stall   = $urandom_range(0, 4) == 0;
    imem_done    = $urandom_range(0, 3) == 0;
    dmem_stall   = $urandom_range(0, 7) == 0;
    dmem_done    = $urandom_range(0, 2) == 0;
    wb_halt      = $urandom_range(0, 149) == 0;
  endtask

  // ---------------- main sequence ----------------
  initial begin : stim
    int bubbles;
    rst = 1'b0;
    idle();
    cmpEn = 1'b1;

    pin("reset outputs", V_RESET);
    nextCyc(); rst = 1'b1;
    pin("run after reset", V_GO);

    // Load-use.
    nextCyc(); idle(); ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 3'd2;
    id_rs = 3'd2; id_rs_used = 1'b1; id_rt = 3'd5; id_rt_used = 1'b1;
    pin("load-use stall", V_HAZ);
    nextCyc(); idle(); mem_rd = 3'd2; mem_regwrite = 1'b1; id_rs = 3'd2; id_rs_used = 1'b1;
    pin("after load bubble", V_ALU_DEP);
    nextCyc(); idle(); ex_memread = 1'b1; ex_regwrite = 1'b0; ex_rd = 3'd2;
    id_rs = 3'd2; id_rs_used = 1'b1;
    pin("load without regwrite", V_GO);
    nextCyc(); idle(); ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 3'd6;
    id_rt = 3'd6; id_rt_used = 1'b1;
    pin("load-use on rt", V_HAZ);
    nextCyc(); idle(); ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 3'd6; id_rs = 3'd6;
    pin("unused source", V_GO);

    // Taken branch in RUN.
    nextCyc(); idle(); ex_br_taken = 1'b1;
    pin("branch squash", V_BRANCH);
    nextCyc(); idle();
    pin("branch no stall", V_GO);

    // DMEM stall with branch held; squash only on release.
    for (int i = 0; i < 4; i++) begin
      nextCyc(); idle(); dmem_stall = 1'b1; ex_br_taken = 1'b1;
      pin("dmem freeze", V_FREEZE);
    end
    nextCyc(); idle(); dmem_done = 1'b1; ex_br_taken = 1'b1;
    pin("dmem release squash", V_BRANCH);
    nextCyc(); idle();
    pin("after dmem", V_GO);

    // IMEM miss with branch mid-wait.
    nextCyc(); idle(); imem_stall = 1'b1;
    pin("imem miss", V_IFWAIT);
    nextCyc(); idle(); imem_stall = 1'b1; ex_br_taken = 1'b1;
    pin("branch in imem wait", V_BRANCH);
    nextCyc(); idle(); imem_stall = 1'b1;
    pin("imem wait", V_IFWAIT);
    nextCyc(); idle(); imem_done = 1'b1;
    pin("imem done discarded", V_GO_NOP);
    nextCyc(); idle();
    pin("run after imem", V_GO);
    nextCyc(); idle(); imem_stall = 1'b1; imem_done = 1'b1;
    pin("stall with done", V_GO);

    // ALU producer walking EX -> MEM -> WB.
    bubbles = 0;
    nextCyc(); idle(); ex_rd = 3'd3; ex_regwrite = 1'b1; id_rs = 3'd3; id_rs_used = 1'b1;
    pin("alu dep in EX", V_ALU_DEP); bubbles += int'(idex_bubble);
    nextCyc(); idle(); mem_rd = 3'd3; mem_regwrite = 1'b1; id_rs = 3'd3; id_rs_used = 1'b1;
    pin("alu dep in MEM", V_ALU_DEP); bubbles += int'(idex_bubble);
    nextCyc(); idle(); wb_rd = 3'd3; wb_regwrite = 1'b1; id_rs = 3'd3; id_rs_used = 1'b1;
    pin("alu dep in WB", V_ALU_DEP); bubbles += int'(idex_bubble);
    nextCyc(); idle(); id_rs = 3'd3; id_rs_used = 1'b1;
    pin("alu dep retired", V_GO); bubbles += int'(idex_bubble);
    compared++;
    if (bubbles != ALU_BUBBLES) begin
      mismatched++;
      $display("FAIL alu bubble count: got %0d want %0d", bubbles, ALU_BUBBLES);
    end

    // Reset in the middle of a data wait.
    nextCyc(); idle(); dmem_stall = 1'b1;
    pin("dmem entry", V_FREEZE);
    @(posedge clk); #3; rst = 1'b0; #1;
    chk("reset mid dwait", V_RESET);
    nextCyc(); idle(); rst = 1'b1;
    pin("run after dwait reset", V_GO);

    // Halt, then asynchronous reset.
    nextCyc(); idle(); wb_halt = 1'b1;
    pin("halt cycle", V_FREEZE);
    for (int i = 0; i < 10; i++) begin
      nextCyc(); idle(); ex_br_taken = 1'b1; imem_stall = i[0]; dmem_done = i[1];
      pin("halted hold", V_HALTED);
    end
    @(posedge clk); #3; rst = 1'b0; #1;
    chk("reset from halt", V_RESET);
    nextCyc(); idle(); rst = 1'b1;
    pin("run after halt reset", V_GO);

    // Randomized traffic checked by the model process.
    for (int c = 0; c < 4000; c++) begin
      nextCyc();
      randomize_inputs();
      if ($urandom_range(0, 299) == 0 || (mHalted && $urandom_range(0, 15) == 0)) begin
        #2;
        rst = 1'b0;
        nextCyc();
        rst = 1'b1;
      end
    end

    nextCyc();
    cmpEn = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
